servo_bank: RTL and testbench
=============================

SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent servo channels (1..16).
REQ-002 SHALL have parameter FRAME_TICKS, default 1_000_000: frame length in clk cycles (20 ms @ 50 MHz).
REQ-003 SHALL have parameter MIN_PULSE_TICK, default 50_000: high time at level 0 (1.0 ms).
REQ-004 SHALL have parameter MAX_PULSE_TICK, default 100_000: high time at level 1000 (2.0 ms).
REQ-005 SHALL have parameter SLEW_STEP, default 10: max level change per channel per frame; 0 disables slew limiting.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid  input  1  command present.
REQ-009 SHALL have port cmd_ready  output  1  command can be accepted this cycle.
REQ-010 SHALL have port cmd_ch  input  max(1,clog2(NUM_CH))  target channel index.
REQ-011 SHALL have port cmd_level  input  10  requested level, 0..1000 meaningful.
REQ-012 SHALL have port enable  input  NUM_CH  per-channel output enable.
REQ-013 SHALL have port pwm_out  output  NUM_CH  servo PWM, one bit per channel.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse at the first cycle of each frame.
REQ-015 SHALL have port busy  output  NUM_CH  channel current level differs from target level.

Function
REQ-016 Frame counter SHALL count 0..FRAME_TICKS-1 and wrap to 0, shared by all channels.
REQ-017 Command SHALL be accepted on the cycle cmd_valid && cmd_ready; accepted level written to target[cmd_ch] on that edge.
REQ-018 cmd_level > 1000 SHALL be clamped to 1000; cmd_ch >= NUM_CH SHALL be accepted and discarded.
REQ-019 cmd_ready SHALL be 1 except when counter == FRAME_TICKS-1 (update cycle), where it SHALL be 0.
REQ-020 On the update cycle each channel SHALL move current toward target by min(|target-current|, SLEW_STEP); SLEW_STEP=0 copies target.
REQ-021 On the update cycle each channel SHALL latch high_count = MIN_PULSE_TICK + ((MAX_PULSE_TICK-MIN_PULSE_TICK)*new_current)/1000, 32-bit intermediate, truncating divide, and latch enable[i].
REQ-022 pwm_out[i] SHALL be registered: high in the cycle after counter value c iff latched enable[i] && c < latched high_count; pulse width per frame exactly high_count cycles, frame period exactly FRAME_TICKS cycles.
REQ-023 Changes to target or enable mid-frame SHALL NOT alter the current frame's pulse (glitch-free).
REQ-024 frame_start SHALL be registered, high for one cycle, aligned with the first high cycle of pwm_out in each frame.
REQ-025 busy[i] SHALL be registered, equal to (current[i] != target[i]), updated one cycle after any change.
REQ-026 Repeated commands to one channel within a frame SHALL leave only the last accepted value in target.

Reset
REQ-027 While rst_n=0: counter=0, all target and current=500, latched high_count=75_000 (default params), latched enable=0, pwm_out=0, frame_start=0, busy=0, cmd_ready=1.
REQ-028 Reset SHALL take effect asynchronously mid-frame and mid-pulse, forcing pwm_out low immediately; first frame after release begins at counter 0 with latched enable=0 (outputs low for that frame).

Structure
REQ-029 Shared package servo_pkg SHALL hold LEVEL_W=10, LEVEL_MAX=1000, LEVEL_RESET=500 and default timing constants.
REQ-030 Per-channel target/current/slew/high_count/enable-latch logic SHALL be sub-module servo_slew_ch, instantiated NUM_CH times; frame counter, handshake and frame_start stay in servo_bank.

Verification (FRAME_TICKS=1000, MIN=50, MAX=100, SLEW_STEP=100, NUM_CH=4)
REQ-031 Release reset, enable=4'hF, no commands -> frame 1 all pwm low; frame 2 onward all channels 75-cycle pulses, period 1000, frame_start every 1000 cycles.
REQ-032 Cmd ch1=1000 mid-frame -> busy[1]=1; widths 80,85,90,95,100 over next five frames; busy[1]=0 after fifth update.
REQ-033 Cmd ch2=1023 -> treated as 1000; cmd ch7 -> no target changes; cmd_valid held during update cycle -> cmd_ready=0, accepted next cycle.
REQ-034 Deassert enable[0] at counter 30 while pulse high -> current pulse completes 75 cycles; next frame pwm_out[0] stays low.
REQ-035 Assert rst_n=0 at counter 40 during pulse -> pwm_out drops same cycle (async); after release counter restarts at 0, targets/currents 500.
REQ-036 SLEW_STEP=0, cmd ch3=0 -> next frame ch3 width 50, busy[3] never exceeds one frame.

Source files
------------

// File: rtl/servo_pkg.sv
// ============================================================================
// servo_pkg : shared level range, timing defaults and pulse-width helpers
// Revision  : 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

   localparam int LEVEL_W     = 10;
   localparam int LEVEL_MAX   = 1000;
   localparam int LEVEL_RESET = 500;

   localparam int DEF_NUM_CH         = 4;
   localparam int DEF_FRAME_TICKS    = 1_000_000;
   localparam int DEF_MIN_PULSE_TICK = 50_000;
   localparam int DEF_MAX_PULSE_TICK = 100_000;
   localparam int DEF_SLEW_STEP      = 10;

   typedef logic [LEVEL_W-1:0] level_t;

   // High time for a level: linear between min and max, truncating divide.
   function automatic logic [31:0] pulse_ticks(input logic [31:0] min_t,
                                               input logic [31:0] max_t,
                                               input level_t      lvl);
      logic [31:0] span;
      span = (max_t - min_t) * {{(32-LEVEL_W){1'b0}}, lvl};
      return min_t + (span / 32'd1000);
   endfunction

   function automatic level_t clamp_level(input level_t lvl);
      return (lvl > level_t'(LEVEL_MAX)) ? level_t'(LEVEL_MAX) : lvl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/servo_slew_ch.sv
// ============================================================================
// servo_slew_ch : one channel's target/current level, slew limiting and
//                 per-frame latch of pulse width and enable
// Revision      : 1.0
// ============================================================================
`default_nettype none

module servo_slew_ch
   import servo_pkg::*;
#(
   parameter int MIN_PULSE_TICK = DEF_MIN_PULSE_TICK,
   parameter int MAX_PULSE_TICK = DEF_MAX_PULSE_TICK,
   parameter int SLEW_STEP      = DEF_SLEW_STEP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_upd,
   input  logic        i_wr,
   input  level_t      i_level,
   input  logic        i_enable,
   output logic [31:0] o_high_count,
   output logic        o_en,
   output logic        o_busy
);

   localparam bit     c_no_limit = (SLEW_STEP == 0) || (SLEW_STEP >= LEVEL_MAX);
   localparam level_t c_step     = level_t'((SLEW_STEP > LEVEL_MAX) ? LEVEL_MAX : SLEW_STEP);

   level_t      r_tgt;
   level_t      r_cur;
   level_t      w_cur_next;
   logic [31:0] r_high_count;
   logic        r_en;
   logic        r_busy;

   always_comb begin
      w_cur_next = r_tgt;
      if (!c_no_limit) begin
         if ((r_tgt > r_cur) && ((r_tgt - r_cur) > c_step)) begin
            w_cur_next = r_cur + c_step;
         end else if ((r_cur > r_tgt) && ((r_cur - r_tgt) > c_step)) begin
            w_cur_next = r_cur - c_step;
         end
      end
   end

   // Width and enable only change at the frame boundary so a frame's pulse is never cut.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgt        <= level_t'(LEVEL_RESET);
         r_cur        <= level_t'(LEVEL_RESET);
         r_high_count <= pulse_ticks(32'(MIN_PULSE_TICK), 32'(MAX_PULSE_TICK),
                                     level_t'(LEVEL_RESET));
         r_en         <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         if (i_wr) begin
            r_tgt <= i_level;
         end
         if (i_upd) begin
            r_cur        <= w_cur_next;
            r_high_count <= pulse_ticks(32'(MIN_PULSE_TICK), 32'(MAX_PULSE_TICK), w_cur_next);
            r_en         <= i_enable;
         end
         r_busy <= (r_cur != r_tgt);
      end
   end

   assign o_high_count = r_high_count;
   assign o_en         = r_en;
   assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: rtl/servo_bank.sv
// ============================================================================
// servo_bank : multi-channel servo PWM generator with shared frame counter,
//              command handshake and per-channel slew-limited levels
// Revision   : 1.0
// ============================================================================
`default_nettype none

module servo_bank
   import servo_pkg::*;
#(
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
   parameter int MIN_PULSE_TICK = DEF_MIN_PULSE_TICK,
   parameter int MAX_PULSE_TICK = DEF_MAX_PULSE_TICK,
   parameter int SLEW_STEP      = DEF_SLEW_STEP
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      cmd_valid,
   output logic                                      cmd_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
   input  logic [LEVEL_W-1:0]                        cmd_level,
   input  logic [NUM_CH-1:0]                         enable,
   output logic [NUM_CH-1:0]                         pwm_out,
   output logic                                      frame_start,
   output logic [NUM_CH-1:0]                         busy
);

   localparam int c_cnt_w = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FRAME_TICKS - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_upd;
   logic               w_accept;
   level_t             w_level;
   logic               r_fs;
   logic [NUM_CH-1:0]  r_pwm;
   logic [NUM_CH-1:0]  w_en;
   logic [31:0]        w_hc [NUM_CH];

   // The last count of the frame is reserved for the channel update, so commands stall there.
   assign w_upd     = (r_cnt == c_last);
   assign cmd_ready = ~w_upd;
   assign w_accept  = cmd_valid & ~w_upd & (32'(cmd_ch) < 32'(NUM_CH));
   assign w_level   = clamp_level(cmd_level);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_upd) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         servo_slew_ch #(
            .MIN_PULSE_TICK (MIN_PULSE_TICK),
            .MAX_PULSE_TICK (MAX_PULSE_TICK),
            .SLEW_STEP      (SLEW_STEP)
         ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_upd        (w_upd),
            .i_wr         (w_accept && (cmd_ch == c_ch_w'(gi))),
            .i_level      (w_level),
            .i_enable     (enable[gi]),
            .o_high_count (w_hc[gi]),
            .o_en         (w_en[gi]),
            .o_busy       (busy[gi])
         );
      end
   endgenerate

   // Registered outputs: frame_start lines up with the first high cycle of every pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fs  <= 1'b0;
         r_pwm <= '0;
      end else begin
         r_fs <= (r_cnt == '0);
         for (int i = 0; i < NUM_CH; i++) begin
            r_pwm[i] <= w_en[i] && (32'(r_cnt) < w_hc[i]);
         end
      end
   end

   assign frame_start = r_fs;
   assign pwm_out     = r_pwm;

endmodule

`default_nettype wire

// File: tb/tb_servo_bank.sv
// ============================================================================
// tb_servo_bank : frame-level reference model check of servo_bank
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_servo_bank;

   localparam int FT   = 1000;
   localparam int MINP = 50;
   localparam int MAXP = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_ch = '0;
   logic [9:0] cmd_level = '0;
   logic [3:0] enable = 4'hF;

   logic       ready_a, ready_b, ready_c;
   logic       fs_a, fs_b, fs_c;
   logic [3:0] pwm_a, pwm_c, busy_a, busy_c;
   logic [2:0] pwm_b, busy_b;

   always #5 clk = ~clk;

   servo_bank #(.NUM_CH(4), .FRAME_TICKS(FT), .MIN_PULSE_TICK(MINP),
                .MAX_PULSE_TICK(MAXP), .SLEW_STEP(100)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
      .cmd_ch(cmd_ch), .cmd_level(cmd_level), .enable(enable),
      .pwm_out(pwm_a), .frame_start(fs_a), .busy(busy_a));

   servo_bank #(.NUM_CH(3), .FRAME_TICKS(FT), .MIN_PULSE_TICK(MINP),
                .MAX_PULSE_TICK(MAXP), .SLEW_STEP(100)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
      .cmd_ch(cmd_ch), .cmd_level(cmd_level), .enable(enable[2:0]),
      .pwm_out(pwm_b), .frame_start(fs_b), .busy(busy_b));

   servo_bank #(.NUM_CH(4), .FRAME_TICKS(FT), .MIN_PULSE_TICK(MINP),
                .MAX_PULSE_TICK(MAXP), .SLEW_STEP(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_c),
      .cmd_ch(cmd_ch), .cmd_level(cmd_level), .enable(enable),
      .pwm_out(pwm_c), .frame_start(fs_c), .busy(busy_c));

   typedef struct {
      int         k;
      bit         is_cmd;
      int         ch;
      int         lvl;
      logic [3:0] en;
   } act_t;

   typedef struct {
      int lvl   [4];
      int exp_w [4];
   } vec_t;

   act_t acts [$];
   vec_t vecs [2];

   int nch  [3] = '{4, 3, 4};
   int slew [3] = '{100, 100, 0};
   int m_tgt [3][4];
   int m_cur [3][4];
   int m_w   [3][4];
   int meas_w[3][4];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [3:0] pwm_of(input int i);
      case (i)
         0:       return pwm_a;
         1:       return {1'b0, pwm_b};
         default: return pwm_c;
      endcase
   endfunction

   function automatic logic [3:0] busy_of(input int i);
      case (i)
         0:       return busy_a;
         1:       return {1'b0, busy_b};
         default: return busy_c;
      endcase
   endfunction

   function automatic logic fs_of(input int i);
      case (i)
         0:       return fs_a;
         1:       return fs_b;
         default: return fs_c;
      endcase
   endfunction

   function automatic logic ready_of(input int i);
      case (i)
         0:       return ready_a;
         1:       return ready_b;
         default: return ready_c;
      endcase
   endfunction

   // Reference model: levels as plain integers, one update per frame.
   task automatic model_reset();
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < 4; c++) begin
            m_tgt[i][c] = 500;
            m_cur[i][c] = 500;
            m_w[i][c]   = 0;
         end
   endtask

   task automatic model_cmd(input int ch, input int lvl);
      for (int i = 0; i < 3; i++)
         if (ch < nch[i]) m_tgt[i][ch] = (lvl > 1000) ? 1000 : lvl;
   endtask

   task automatic model_update();
      int d;
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < nch[i]; c++) begin
            d = m_tgt[i][c] - m_cur[i][c];
            if (slew[i] == 0 || (d <= slew[i] && d >= -slew[i])) m_cur[i][c] = m_tgt[i][c];
            else if (d > 0) m_cur[i][c] += slew[i];
            else m_cur[i][c] -= slew[i];
            m_w[i][c] = enable[c] ? MINP + ((MAXP - MINP) * m_cur[i][c]) / 1000 : 0;
         end
   endtask

   task automatic summary_and_finish();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   task automatic wait_fs(output int waited);
      waited = 0;
      while (!fs_a && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (!fs_a) begin
         check("frame_start timeout", 0, 1);
         summary_and_finish();
      end
   endtask

   // Runs one frame window starting at the negedge where frame_start is high.
   task automatic run_frame();
      int         cnt [3][4];
      int         bad [3][4];
      int         fs_n[3];
      int         fs0 [3];
      logic [3:0] p;
      logic [3:0] em;
      bit         hold;
      act_t       deferred[$];
      hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fs_n[i] = 0;
         fs0[i]  = 0;
         for (int c = 0; c < 4; c++) begin
            cnt[i][c] = 0;
            bad[i][c] = 0;
         end
      end
      for (int k = 0; k < FT; k++) begin
         if (!hold) cmd_valid = 1'b0;
         for (int i = 0; i < 3; i++) begin
            p = pwm_of(i);
            for (int c = 0; c < nch[i]; c++)
               if (p[c]) begin
                  if (cnt[i][c] != k) bad[i][c]++;
                  cnt[i][c]++;
               end
            if (fs_of(i)) begin
               fs_n[i]++;
               if (k == 0) fs0[i] = 1;
            end
         end
         foreach (acts[j])
            if (acts[j].k == k) begin
               if (acts[j].is_cmd) begin
                  cmd_valid = 1'b1;
                  cmd_ch    = 2'(acts[j].ch);
                  cmd_level = 10'(acts[j].lvl);
                  if (k == FT - 2) begin
                     hold = 1'b1;
                     deferred.push_back(acts[j]);
                  end else begin
                     model_cmd(acts[j].ch, acts[j].lvl);
                  end
               end else begin
                  enable = acts[j].en;
               end
            end
         if (k == 995)
            for (int i = 0; i < 3; i++) begin
               em = '0;
               for (int c = 0; c < nch[i]; c++) em[c] = (m_cur[i][c] != m_tgt[i][c]);
               check($sformatf("busy inst%0d", i), busy_of(i), em);
            end
         if (k == FT - 3) for (int i = 0; i < 3; i++) check($sformatf("ready before update inst%0d", i), ready_of(i), 1);
         if (k == FT - 2) for (int i = 0; i < 3; i++) check($sformatf("ready in update inst%0d", i), ready_of(i), 0);
         if (k == FT - 1) for (int i = 0; i < 3; i++) check($sformatf("ready after update inst%0d", i), ready_of(i), 1);
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < nch[i]; c++) begin
            check($sformatf("width inst%0d ch%0d", i, c), cnt[i][c], m_w[i][c]);
            check($sformatf("pulse shape inst%0d ch%0d", i, c), bad[i][c], 0);
            meas_w[i][c] = cnt[i][c];
         end
         check($sformatf("frame_start count inst%0d", i), fs_n[i], 1);
         check($sformatf("frame_start at start inst%0d", i), fs0[i], 1);
      end
      check("frame period", fs_a, 1);
      model_update();
      foreach (deferred[j]) model_cmd(deferred[j].ch, deferred[j].lvl);
      acts.delete();
      cmd_valid = 1'b0;
   endtask

   task automatic add_cmd(input int k, input int ch, input int lvl);
      act_t a;
      a.k = k; a.is_cmd = 1'b1; a.ch = ch; a.lvl = lvl; a.en = '0;
      acts.push_back(a);
   endtask

   task automatic add_en(input int k, input logic [3:0] en);
      act_t a;
      a.k = k; a.is_cmd = 1'b0; a.ch = 0; a.lvl = 0; a.en = en;
      acts.push_back(a);
   endtask

   initial begin
      int w;
      int slew_exp[5] = '{80, 85, 90, 95, 100};

      vecs[0].lvl = '{1000, 250, 0, 1023}; vecs[0].exp_w = '{100, 62, 50, 100};
      vecs[1].lvl = '{999, 1, 20, 19};     vecs[1].exp_w = '{99, 50, 51, 50};

      // Reset state
      rst_n  = 1'b0;
      enable = 4'hF;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset pwm inst%0d", i), pwm_of(i), 0);
         check($sformatf("reset frame_start inst%0d", i), fs_of(i), 0);
         check($sformatf("reset busy inst%0d", i), busy_of(i), 0);
         check($sformatf("reset ready inst%0d", i), ready_of(i), 1);
      end
      rst_n = 1'b1;
      model_reset();
      wait_fs(w);
      check("first frame_start latency", w, 1);

      // Frame 1 outputs low, then 75-cycle pulses
      run_frame();
      run_frame();

      // Slew from 500 to 1000 in steps of 100
      add_cmd(500, 1, 1000);
      run_frame();
      for (int f = 0; f < 5; f++) begin
         run_frame();
         check($sformatf("slew width frame%0d", f), meas_w[0][1], slew_exp[f]);
      end

      // Command held across the update cycle, clamped level
      add_cmd(FT - 2, 2, 1023);
      run_frame();
      run_frame();

      // Repeated commands: last one wins
      add_cmd(100, 0, 0);
      add_cmd(200, 0, 900);
      run_frame();

      // Enable dropped mid-pulse
      add_en(29, 4'hE);
      run_frame();
      run_frame();
      check("disabled ch0 width", meas_w[0][0], 0);
      add_en(10, 4'hF);
      run_frame();

      // Instant move with no slew limit
      add_cmd(300, 3, 0);
      run_frame();
      run_frame();
      check("no-slew ch3 width", meas_w[2][3], 50);

      // Table of settled levels
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) add_cmd(100 + c, c, vecs[r].lvl[c]);
         for (int f = 0; f < 11; f++) run_frame();
         for (int c = 0; c < 4; c++)
            check($sformatf("table row%0d ch%0d width", r, c), meas_w[0][c], vecs[r].exp_w[c]);
         check($sformatf("table row%0d discard ch3", r), busy_b, 0);
      end

      // Asynchronous reset in the middle of a pulse
      repeat (39) @(negedge clk);
      check("pre-reset pwm ch0", pwm_a[0], (m_w[0][0] > 39) ? 1 : 0);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("async reset pwm inst%0d", i), pwm_of(i), 0);
         check($sformatf("async reset busy inst%0d", i), busy_of(i), 0);
         check($sformatf("async reset ready inst%0d", i), ready_of(i), 1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_fs(w);
      check("restart frame_start latency", w, 1);
      run_frame();
      run_frame();

      // Random commands and enable changes
      for (int f = 0; f < 15; f++) begin
         int n;
         n = int'($urandom_range(0, 4));
         for (int j = 0; j < n; j++)
            add_cmd(150 * j + int'($urandom_range(1, 140)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1023)));
         if ($urandom_range(0, 2) == 0) add_en(900, 4'($urandom_range(0, 15)));
         run_frame();
      end

      summary_and_finish();
   end

endmodule

`default_nettype wire
